// File: rtl/kbd_event_decoder.sv
// PS/2 frame decoder: validates 11-bit frames, folds E0/F0 prefixes into key events, buffers them in a FIFO.
// Optional saturating error counter enabled by defining KBD_ERR_CNT_EN.
module kbd_event_decoder #(
  parameter int DATA_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  axis_aclk_i,
  input  logic                  axis_areset_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic [9:0]            m_axis_tdata_o,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0]       CODE_EXT = 8'hE0;
  localparam logic [7:0]       CODE_BRK = 8'hF0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } event_t;

  state_t           state;
  state_t           state_nxt;
  event_t           evt;
  logic [7:0]       code;
  logic             accept;
  logic             frame_ok;
  logic             is_prefix;
  logic             push;
  logic             pop;
  logic             err_nxt;

  event_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Frame layout: [0] start, [8:1] data LSB-first, [9] odd parity, [10] stop.
  assign accept    = s_axis_tvalid_i & s_axis_tready_o;
  assign code      = s_axis_tdata_i[8:1];
  assign frame_ok  = ~s_axis_tdata_i[0] & s_axis_tdata_i[10] & (^s_axis_tdata_i[9:1]);
  assign is_prefix = (code == CODE_EXT) || (code == CODE_BRK);

  // Flags come from the state the code arrives in, before the transition.
  assign evt.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign evt.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign evt.code = code;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_nxt   = 1'b0;
    if (accept) begin
      if (!frame_ok) begin
        err_nxt   = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (code == CODE_EXT)      state_nxt = ST_EXT;
            else if (code == CODE_BRK) state_nxt = ST_BRK;
            else                       push      = 1'b1;
          end
          ST_EXT: begin
            if (code == CODE_BRK) begin
              state_nxt = ST_EXT_BRK;
            end else begin
              err_nxt   = (code == CODE_EXT);
              push      = (code != CODE_EXT);
              state_nxt = ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            // A stray prefix here is dropped, never re-interpreted as a new prefix.
            err_nxt   = is_prefix;
            push      = !is_prefix;
            state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      state <= ST_IDLE;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      err_o <= err_nxt;
    end
  end

  // A push only happens while tready is high, which already guarantees a free slot.
  assign pop = m_axis_tvalid_o & m_axis_tready_i;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      s_axis_tready_o <= 1'b1;
      m_axis_tvalid_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count           <= count_nxt;
      // Flags track the next occupancy so tready falls on the edge the last slot fills.
      s_axis_tready_o <= (count_nxt != CNT_FULL);
      m_axis_tvalid_o <= (count_nxt != '0);
    end
  end

  // NOTE: the storage array has no reset; empty slots are never observable because tdata is gated by tvalid.
  always_ff @(posedge axis_aclk_i) begin
    if (push) mem[wr_ptr] <= evt;
  end

  assign m_axis_tdata_o = m_axis_tvalid_o ? mem[rd_ptr] : '0;

`ifdef KBD_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      err_cnt <= 8'h00;
    end else if (err_o && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = 8'h00;
`endif

endmodule
